// File: rtl/gift_dec_word_loader.sv
// -----------------------------------------------------------------------------
// gift_dec_word_loader
//
// Input stage for the pipelined GIFT-128 decryption core. A 32-bit word stream
// with a valid/ready handshake is assembled into 128-bit key and ciphertext
// blocks. Completed blocks are written to the core with single-cycle strobes.
// Before a new key is written, the core pipeline is drained. Blocks already in
// flight therefore finish under the key they entered with.
//
// Parameters:
//   PIPE_DEPTH    cycles from a data write until that block leaves the core.
//                 Legal range is 1..255.
//
// Ports:
//   inClk         clock; all state updates happen on the rising edge
//   inRstN        asynchronous active-low reset
//   inWordValid   upstream word valid
//   inWordIsKey   1 = word belongs to a key block, 0 = ciphertext block
//   inWordData    32-bit word; the first word of a block is bits [127:96]
//   outWordReady  a word is accepted when inWordValid & outWordReady
//   outKeyWr      one-cycle key write strobe
//   outKeyData    assembled key; updated only on outKeyWr
//   outDataWr     one-cycle data write strobe
//   outDataData   assembled ciphertext; updated only on outDataWr
//   outKeyLoaded  a key has been issued to the core since reset
//   outProtoErr   one-cycle pulse on a type change or a data block with no key
// -----------------------------------------------------------------------------
module gift_dec_word_loader #(
  parameter int PIPE_DEPTH = 41
) (
  input  logic         inClk,
  input  logic         inRstN,
  input  logic         inWordValid,
  input  logic         inWordIsKey,
  input  logic [31:0]  inWordData,
  output logic         outWordReady,
  output logic         outKeyWr,
  output logic [127:0] outKeyData,
  output logic         outDataWr,
  output logic [127:0] outDataData,
  output logic         outKeyLoaded,
  output logic         outProtoErr
);

  localparam logic [0:0] ST_COLLECT = 1'b0;
  localparam logic [0:0] ST_DRAIN   = 1'b1;

  localparam logic [7:0] DRAIN_LOAD = 8'(PIPE_DEPTH);

  logic [0:0]   state;
  logic [1:0]   word_cnt;
  logic         blk_is_key;
  logic [127:0] asm_reg;
  logic [7:0]   drain_cnt;

  logic         key_wr;
  logic         data_wr;
  logic         proto_err;
  logic         key_loaded;
  logic [127:0] key_data;
  logic [127:0] data_data;

  logic         accept;
  logic         type_err;
  logic [127:0] next_blk;

  // Ready is gated by reset so that no word is taken while inRstN is low.
  assign outWordReady = inRstN && (state == ST_COLLECT);
  assign accept       = inWordValid && outWordReady;

  // A word whose type differs from the latched block type restarts assembly.
  // Without that error, the type of an accepted word always equals the block
  // type, so inWordIsKey alone identifies the block that is completing.
  assign type_err = accept && (word_cnt != 2'd0) && (inWordIsKey != blk_is_key);
  assign next_blk = {asm_reg[95:0], inWordData};

  // NOTE: sequential state uses non-blocking assignments only. Every register
  // then samples values from before the edge, regardless of statement order.
  // NOTE: the wide assembly and output registers are reset as well. A pulse
  // of inRstN then leaves no stale key or ciphertext visible to the core.
  always_ff @(posedge inClk or negedge inRstN) begin
    if (!inRstN) begin
      state      <= ST_COLLECT;
      word_cnt   <= 2'd0;
      blk_is_key <= 1'b0;
      asm_reg    <= '0;
      drain_cnt  <= 8'd0;
      key_wr     <= 1'b0;
      data_wr    <= 1'b0;
      proto_err  <= 1'b0;
      key_loaded <= 1'b0;
      key_data   <= '0;
      data_data  <= '0;
    end else begin
      key_wr    <= 1'b0;
      data_wr   <= 1'b0;
      proto_err <= 1'b0;

      // Saturating countdown. A data write later in this block overrides it
      // with a reload.
      if (drain_cnt != 8'd0) begin
        drain_cnt <= drain_cnt - 8'd1;
      end

      case (state)
        ST_COLLECT: begin
          if (accept) begin
            blk_is_key <= inWordIsKey;
            if (type_err) begin
              // Drop the partial block; the offending word becomes word 0.
              asm_reg   <= {96'd0, inWordData};
              word_cnt  <= 2'd1;
              proto_err <= 1'b1;
            end else begin
              asm_reg  <= next_blk;
              word_cnt <= word_cnt + 2'd1;
              if (word_cnt == 2'd3) begin
                if (inWordIsKey) begin
                  if (drain_cnt == 8'd0) begin
                    key_wr     <= 1'b1;
                    key_data   <= next_blk;
                    key_loaded <= 1'b1;
                  end else begin
                    // The key stays in asm_reg; no words arrive while draining.
                    state <= ST_DRAIN;
                  end
                end else if (key_loaded) begin
                  data_wr   <= 1'b1;
                  data_data <= next_blk;
                  drain_cnt <= DRAIN_LOAD;
                end else begin
                  proto_err <= 1'b1;
                end
              end
            end
          end
        end

        ST_DRAIN: begin
          if (drain_cnt == 8'd0) begin
            key_wr     <= 1'b1;
            key_data   <= asm_reg;
            key_loaded <= 1'b1;
            state      <= ST_COLLECT;
          end
        end

        default: state <= ST_COLLECT;
      endcase
    end
  end

  assign outKeyWr     = key_wr;
  assign outKeyData   = key_data;
  assign outDataWr    = data_wr;
  assign outDataData  = data_data;
  assign outKeyLoaded = key_loaded;
  assign outProtoErr  = proto_err;

endmodule

// File: tb/tb_gift_dec_word_loader.sv
// -----------------------------------------------------------------------------
// tb_gift_dec_word_loader
//
// Directed testbench for gift_dec_word_loader with PIPE_DEPTH = 4. Inputs are
// driven 1 ns after the rising edge. Outputs are checked at that same point,
// so each check sees the result of the edge that has just passed.
// -----------------------------------------------------------------------------
module tb_gift_dec_word_loader;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         word_valid = 1'b0;
  logic         word_is_key = 1'b0;
  logic [31:0]  word_data = 32'd0;
  logic         word_ready;
  logic         key_wr;
  logic [127:0] key_data;
  logic         data_wr;
  logic [127:0] data_data;
  logic         key_loaded;
  logic         proto_err;

  int errors = 0;
  int checks = 0;

  // Strobe counters, updated on the falling edge by the monitor below.
  int key_wr_cnt   = 0;
  int data_wr_cnt  = 0;
  int proto_err_cnt = 0;
  bit both_wr_seen = 1'b0;

  localparam logic [127:0] KEY_A = 128'h00112233_44556677_8899AABB_CCDDEEFF;
  localparam logic [127:0] KEY_B = 128'h0F1E2D3C_4B5A6978_8796A5B4_C3D2E1F0;

  gift_dec_word_loader #(.PIPE_DEPTH(4)) dut (
    .inClk        (clk),
    .inRstN       (rst_n),
    .inWordValid  (word_valid),
    .inWordIsKey  (word_is_key),
    .inWordData   (word_data),
    .outWordReady (word_ready),
    .outKeyWr     (key_wr),
    .outKeyData   (key_data),
    .outDataWr    (data_wr),
    .outDataData  (data_data),
    .outKeyLoaded (key_loaded),
    .outProtoErr  (proto_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (key_wr)    key_wr_cnt++;
    if (data_wr)   data_wr_cnt++;
    if (proto_err) proto_err_cnt++;
    if (key_wr && data_wr) both_wr_seen = 1'b1;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic is_key, input logic [31:0] data);
    word_valid  = 1'b1;
    word_is_key = is_key;
    word_data   = data;
    @(posedge clk);
    #1;
    word_valid  = 1'b0;
  endtask

  task automatic send_block(input logic is_key, input logic [127:0] blk);
    send_word(is_key, blk[127:96]);
    send_word(is_key, blk[95:64]);
    send_word(is_key, blk[63:32]);
    send_word(is_key, blk[31:0]);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    step();
    @(negedge clk);
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #2;
    checks++;
    if (word_ready !== 1'b0) begin
      errors++; $display("FAIL reset_ready: got %b expected 0", word_ready);
    end
    step();
    checks++;
    if ({key_wr, data_wr, proto_err, key_loaded} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_flags: got %b expected 0000",
               {key_wr, data_wr, proto_err, key_loaded});
    end
    checks++;
    if (key_data !== 128'd0 || data_data !== 128'd0) begin
      errors++; $display("FAIL reset_data: got %h / %h expected 0", key_data, data_data);
    end
    @(negedge clk);
    rst_n = 1'b1;
    step();
    checks++;
    if (word_ready !== 1'b1) begin
      errors++; $display("FAIL reset_release_ready: got %b expected 1", word_ready);
    end
  endtask

  // Scenario 1: a key block loaded straight after reset.
  task automatic test_key_load();
    send_block(1'b1, KEY_A);
    checks++;
    if (key_wr !== 1'b1) begin
      errors++; $display("FAIL key_wr_strobe: got %b expected 1", key_wr);
    end
    checks++;
    if (key_data !== KEY_A) begin
      errors++; $display("FAIL key_data: got %h expected %h", key_data, KEY_A);
    end
    checks++;
    if (key_loaded !== 1'b1) begin
      errors++; $display("FAIL key_loaded: got %b expected 1", key_loaded);
    end
    step();
    checks++;
    if (key_wr !== 1'b0 || key_data !== KEY_A) begin
      errors++;
      $display("FAIL key_wr_one_cycle: got wr=%b data=%h expected wr=0 data=%h",
               key_wr, key_data, KEY_A);
    end
  endtask

  // Scenario 2: a data block with no key is dropped with one error pulse.
  task automatic test_data_no_key();
    int err0, dw0;
    do_reset();
    err0 = proto_err_cnt;
    dw0  = data_wr_cnt;
    send_block(1'b0, 128'hDEADBEEF_01234567_89ABCDEF_FEEDFACE);
    checks++;
    if (proto_err !== 1'b1 || data_wr !== 1'b0) begin
      errors++;
      $display("FAIL nokey_err: got err=%b wr=%b expected err=1 wr=0", proto_err, data_wr);
    end
    step();
    step();
    checks++;
    if (proto_err_cnt - err0 !== 1 || data_wr_cnt - dw0 !== 0) begin
      errors++;
      $display("FAIL nokey_counts: got err=%0d wr=%0d expected err=1 wr=0",
               proto_err_cnt - err0, data_wr_cnt - dw0);
    end
    checks++;
    if (word_ready !== 1'b1 || data_data !== 128'd0) begin
      errors++;
      $display("FAIL nokey_ready: got rdy=%b data=%h expected rdy=1 data=0",
               word_ready, data_data);
    end
  endtask

  // Scenarios 3 and 4: three back-to-back data blocks, then a key that
  // must wait for the pipeline to drain.
  task automatic test_back_to_back();
    logic [31:0]  w;
    logic [127:0] exp_blk;
    send_block(1'b1, KEY_A);
    exp_blk = '0;
    for (int b = 0; b < 3; b++) begin
      for (int i = 0; i < 4; i++) begin
        w = 32'hC0DE0000 | (32'(b) << 8) | 32'(i);
        exp_blk = {exp_blk[95:0], w};
        send_word(1'b0, w);
        checks++;
        if (data_wr !== (i == 3)) begin
          errors++;
          $display("FAIL b2b_strobe blk%0d word%0d: got %b expected %b", b, i, data_wr, i == 3);
        end
      end
      checks++;
      if (data_data !== exp_blk) begin
        errors++; $display("FAIL b2b_data blk%0d: got %h expected %h", b, data_data, exp_blk);
      end
    end
    // The data strobe of the last block is high now; the key follows at once.
    send_block(1'b1, KEY_B);
    checks++;
    if (word_ready !== 1'b0 || key_wr !== 1'b0) begin
      errors++;
      $display("FAIL drain_hold: got rdy=%b kwr=%b expected rdy=0 kwr=0", word_ready, key_wr);
    end
    step();
    checks++;
    if (key_wr !== 1'b1 || word_ready !== 1'b1) begin
      errors++;
      $display("FAIL drain_release: got kwr=%b rdy=%b expected kwr=1 rdy=1", key_wr, word_ready);
    end
    checks++;
    if (key_data !== KEY_B) begin
      errors++; $display("FAIL drain_key_data: got %h expected %h", key_data, KEY_B);
    end
  endtask

  // Scenario 5: a type change mid-block restarts with the offending word.
  task automatic test_type_change();
    int err0, kw0;
    logic [127:0] exp_blk;
    exp_blk = 128'hA1A1A1A1_B2B2B2B2_C3C3C3C3_D4D4D4D4;
    step();
    err0 = proto_err_cnt;
    kw0  = key_wr_cnt;
    send_word(1'b1, 32'h11111111);
    send_word(1'b1, 32'h22222222);
    send_word(1'b0, exp_blk[127:96]);
    checks++;
    if (proto_err !== 1'b1) begin
      errors++; $display("FAIL type_err_pulse: got %b expected 1", proto_err);
    end
    send_word(1'b0, exp_blk[95:64]);
    checks++;
    if (proto_err !== 1'b0) begin
      errors++; $display("FAIL type_err_one_cycle: got %b expected 0", proto_err);
    end
    send_word(1'b0, exp_blk[63:32]);
    send_word(1'b0, exp_blk[31:0]);
    checks++;
    if (data_wr !== 1'b1 || data_data !== exp_blk) begin
      errors++;
      $display("FAIL type_new_block: got wr=%b data=%h expected wr=1 data=%h",
               data_wr, data_data, exp_blk);
    end
    step();
    checks++;
    if (proto_err_cnt - err0 !== 1 || key_wr_cnt - kw0 !== 0 || key_data !== KEY_B) begin
      errors++;
      $display("FAIL type_counts: got err=%0d kwr=%0d key=%h expected 1 0 %h",
               proto_err_cnt - err0, key_wr_cnt - kw0, key_data, KEY_B);
    end
  endtask

  // Scenario 6: reset mid-block and during DRAIN discards everything.
  task automatic test_reset_mid();
    int kw0;
    send_word(1'b1, KEY_A[127:96]);
    send_word(1'b1, KEY_A[95:64]);
    send_word(1'b1, KEY_A[63:32]);
    rst_n = 1'b0;
    #1;
    checks++;
    if (word_ready !== 1'b0 || key_loaded !== 1'b0 || key_data !== 128'd0
        || data_data !== 128'd0) begin
      errors++;
      $display("FAIL rst_mid_outputs: got rdy=%b ld=%b key=%h data=%h expected all 0",
               word_ready, key_loaded, key_data, data_data);
    end
    @(negedge clk);
    rst_n = 1'b1;
    step();
    // This would have been the fourth word; after reset it is only word 0.
    send_word(1'b1, KEY_A[31:0]);
    checks++;
    if (key_wr !== 1'b0) begin
      errors++; $display("FAIL rst_mid_no_key: got %b expected 0", key_wr);
    end

    // Build up to DRAIN, then reset during it.
    do_reset();
    send_block(1'b1, KEY_A);
    send_block(1'b0, 128'h55555555_66666666_77777777_88888888);
    send_block(1'b1, KEY_B);
    checks++;
    if (word_ready !== 1'b0) begin
      errors++; $display("FAIL rst_drain_entered: got rdy=%b expected 0", word_ready);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({key_wr, data_wr, proto_err, key_loaded, word_ready} !== 5'b00000
        || key_data !== 128'd0 || data_data !== 128'd0) begin
      errors++;
      $display("FAIL rst_drain_outputs: got flags=%b key=%h data=%h expected all 0",
               {key_wr, data_wr, proto_err, key_loaded, word_ready}, key_data, data_data);
    end
    kw0 = key_wr_cnt;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) step();
    checks++;
    if (key_wr_cnt - kw0 !== 0 || key_data !== 128'd0) begin
      errors++;
      $display("FAIL rst_drain_no_key: got kwr=%0d key=%h expected 0 0",
               key_wr_cnt - kw0, key_data);
    end
    // A fresh key block behaves as it does straight after reset.
    test_key_load();
  endtask

  task automatic test_exclusive();
    checks++;
    if (both_wr_seen !== 1'b0) begin
      errors++; $display("FAIL write_exclusive: got both strobes high, expected never");
    end
  endtask

  initial begin
    test_reset();
    test_key_load();
    test_data_no_key();
    test_back_to_back();
    test_type_change();
    test_reset_mid();
    test_exclusive();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/gift_dec_word_loader.md
Name: gift_dec_word_loader

Overview:
Upstream input stage for the pipelined GIFT-128 decryption core. It takes a 32-bit word stream with valid/ready handshake and assembles the words into 128-bit key and ciphertext blocks. It then issues single-cycle key-write and data-write strobes with 128-bit buses that drive the core's key and data inputs directly. Before any new key is written, it drains the core pipeline, so blocks already in flight always finish under the key they entered with.

Parameters:
PIPE_DEPTH, 41, cycles from a core data write until that block has left the pipeline; minimum spacing between the last data write and a following key write (legal range 1..255).

Ports:
inClk  input  1  clock; all state updates on rising edge
inRstN  input  1  asynchronous active-low reset
inWordValid  input  1  upstream word valid
inWordIsKey  input  1  1 = word belongs to a key block, 0 = ciphertext block; sampled with each word
inWordData  input  32  word payload; first word of a block is bits [127:96], fourth is [31:0]
outWordReady  output  1  loader accepts a word this cycle; transfer when inWordValid & outWordReady
outKeyWr  output  1  one-cycle strobe to core key write
outKeyData  output  128  assembled key, valid while outKeyWr=1 and held afterwards
outDataWr  output  1  one-cycle strobe to core data write
outDataData  output  128  assembled ciphertext, valid while outDataWr=1 and held afterwards
outKeyLoaded  output  1  a key has been issued to the core since reset
outProtoErr  output  1  one-cycle pulse on protocol violation (see below)

Behaviour:
- Reset (async assert, sync deassert handled externally):
  - State = COLLECT; word counter = 0; assembly register = 0; drain counter = 0.
  - outKeyWr=0, outDataWr=0, outProtoErr=0, outKeyLoaded=0, outKeyData=0, outDataData=0.
  - outWordReady=0 while inRstN=0.
- Reset mid-block or during DRAIN discards all partial or pending data. No strobe is issued afterwards.
- State COLLECT: outWordReady=1.
  - Each accepted word shifts into the assembly register, MSW first.
  - Word counter runs 0..3 and wraps to 0 after the fourth word.
  - The block type is latched from inWordIsKey on word 0.
- Type change mid-block (counter != 0 and inWordIsKey != latched type):
  - The partial block is discarded and outProtoErr pulses on the next cycle.
  - The offending word is taken as word 0 of a new block of the new type; counter becomes 1.
- Fourth word accepted, data block:
  - If outKeyLoaded=1: on the next cycle outDataWr=1 for exactly one cycle and outDataData = {w0,w1,w2,w3}. The drain counter loads PIPE_DEPTH in that same cycle.
  - If outKeyLoaded=0: the block is dropped, outProtoErr pulses once, and no outDataWr is issued.
  - Stay in COLLECT. Sustained throughput is one block per 4 cycles with no bubbles.
- Fourth word accepted, key block:
  - If drain counter = 0: on the next cycle outKeyWr=1 for one cycle with outKeyData = assembled key, and outKeyLoaded sets. Stay in COLLECT.
  - If drain counter != 0: go to DRAIN and hold the key.
- State DRAIN:
  - outWordReady=0; no words are accepted.
  - The drain counter decrements by 1 each cycle.
  - In the cycle after it reaches 0, outKeyWr pulses with the held key, outKeyLoaded sets, and the state returns to COLLECT with outWordReady=1 in that same cycle.
- Drain counter:
  - 8-bit, saturating at 0.
  - Reloads to PIPE_DEPTH on every outDataWr cycle; otherwise decrements each cycle while nonzero.
- Write exclusivity: outKeyWr and outDataWr are never high in the same cycle. outKeyWr is never issued while the drain counter is nonzero.
- Output registers: outKeyData and outDataData change only on their own strobe cycles.
- Protocol-error priority: if a type-change error and a completed block coincide, the completed block is the new one. A single outProtoErr pulse covers the type-change error.
- Reference implementation size: ~200 lines RTL; two-state FSM plus counters.

Test Plan:
1. Reset, then key words 0x00112233, 0x44556677, 0x8899AABB, 0xCCDDEEFF with inWordIsKey=1 on consecutive cycles -> outKeyWr high for one cycle, one cycle after the 4th word; outKeyData = 0x00112233_44556677_8899AABB_CCDDEEFF; outKeyLoaded=1.
2. After reset, with no key loaded, send 4 data words -> no outDataWr; outProtoErr pulses once; outWordReady stays 1.
3. With a key loaded and PIPE_DEPTH=4, stream 3 back-to-back data blocks -> outDataWr pulses every 4 cycles, each with the correct 128-bit value.
4. With PIPE_DEPTH=4, send a data block then immediately a key block -> outWordReady drops after the 4th key word; outKeyWr is issued exactly when the drain counter has expired (no earlier than 5 cycles after outDataWr); outWordReady returns to 1 in that same cycle.
5. Send 2 key words, then 1 data word -> outProtoErr pulses once; the data word becomes word 0; 3 more data words produce outDataWr containing that word in bits [127:96].
6. Deassert inRstN after 3 key words and during DRAIN -> all outputs return to reset values immediately; the next complete key block behaves as in scenario 1.
